irq_ctl: RTL and testbench
==========================

Name: irq_ctl

Overview:
- Interrupt controller feeding the AVR core's `intr`/`vect` inputs.
- Collects rising-edge events from peripheral strobes (vblank, kdone, mouse recv, sd_done, etc.) plus one built-in periodic tick.
- Latches the events into a pending register, masks them, and presents the highest-priority vector.
- Sits on the CPU data bus in the I/O port window; the top level muxes its read data into the port read path alongside `io`.

Parameters:
- BASE, 16'h005C, address of register 0; registers occupy BASE..BASE+3 (must stay inside the 16'h0000..16'h005F port window).
- TICK_DIV, 25000, internal tick period in clocks (1 kHz at 25 MHz); legal range 2..65535.

Ports:
- clock  input  1  system clock (clock_25 domain)
- reset  input  1  asynchronous, active-high reset
- src  input  7  event lines, bit n = interrupt source n (n=0..6); rising edge = event
- a  input  16  CPU data address
- o  input  8  CPU write data
- w  input  1  CPU write strobe (one cycle)
- r  input  1  CPU read strobe (informational; reads have no side effects)
- q  output  8  read data, combinational from a; 8'h00 when a is outside BASE..BASE+3
- intr  output  1  interrupt request, level
- vect  output  3  vector of highest-priority active request

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All registers clear to 0 on reset, including during an in-flight edge or timer count.
- Reset values: MASK=0, PEND=0, TCTL=0, tick counter=0, edge-detect history=0, intr=0, vect=0.
- Register map (offset from BASE):
  - +0 MASK, R/W. Bit n enables source n; bit 7 enables the internal tick.
  - +1 PEND, read returns pending bits. A write of 1 clears that bit; a write of 0 has no effect.
  - +2 STAT, read-only: {intr, 4'b0, vect}. Writes are ignored.
  - +3 TCTL, R/W, bit0 = tick run; bits 7:1 read 0.
- Edge detect: each src bit is registered, and event = registered value & ~previous registered value.
  - src first sampled high at edge k sets PEND[n] at edge k+1.
  - A level held high produces exactly one event; it must fall and rise again to produce another.
- Tick (source 7):
  - While TCTL[0]=1, the 16-bit counter runs 0..TICK_DIV-1 and wraps.
  - On the wrap edge (counter == TICK_DIV-1), PEND[7] is set.
  - Writing TCTL[0]=0 clears the counter to 0 on the same edge; re-enabling restarts from 0.
- PEND is set regardless of MASK. Masking only gates intr and vect; unmasking later with a bit already pending raises intr immediately.
- Simultaneous set and W1C on the same bit in the same cycle: set wins, so the bit stays 1.
- intr = |(PEND & MASK), registered, one cycle after PEND/MASK change.
- vect = index of the lowest set bit of (PEND & MASK); bit 0 is highest priority. vect is registered alongside intr and is 0 when intr=0.
- No auto-acknowledge: the ISR must W1C its PEND bit. intr stays high while any enabled bit remains pending.
- Writes to addresses outside BASE..BASE+3 are ignored. Reads never modify state.

Optional Feature:
- IRQ_SYNC_EN defined: each src bit passes through a 2-flop synchronizer before edge detection. Latency becomes src high at edge k -> PEND at edge k+2. This is for asynchronous sources (e.g. raw PS/2-domain strobes).
- Not defined: single-register sampling as above, latency k+1. src must be synchronous to clock.

Test Plan:
- Reset, then read BASE..BASE+3 -> all 8'h00; intr=0, vect=0; read of BASE+4 -> 8'h00.
- MASK=8'h04; pulse src[2] for 1 clock -> PEND=8'h04 at k+1, intr=1 and vect=2 at k+2. Write PEND 8'h04 -> PEND=0, intr=0 next cycle.
- MASK=8'hFF; raise src[5] and src[1] in the same cycle -> vect=1. Clear bit 1 -> vect=5 with intr still 1. Clear bit 5 -> intr=0.
- MASK=0; pulse src[3] -> PEND=8'h08, intr=0. Write MASK=8'h08 -> intr=1, vect=3 one cycle later.
- TICK_DIV=10, MASK=8'h80, TCTL=1 -> PEND[7] set every 10 clocks. Issue W1C of bit 7 in the same cycle as the wrap -> PEND[7] stays 1. TCTL=0 mid-count then TCTL=1 -> next set exactly 10 clocks after re-enable.
- Hold src[0] high 50 cycles -> exactly one event. Assert reset mid-count with PEND=8'hFF -> all state 0 immediately (asynchronous).
- With IRQ_SYNC_EN -> src[0] edge lands in PEND at k+2.

Source files
------------

// File: rtl/irq_ctl.sv
// Interrupt controller: edge-detected peripheral strobes plus a periodic tick, latched, masked and
// priority-encoded into intr/vect. Define IRQ_SYNC_EN to add a 2-flop synchronizer on each src bit.
module irq_ctl #(
  parameter logic [15:0] BASE     = 16'h005C,
  parameter int unsigned TICK_DIV = 25000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  src,
  input  logic [15:0] a,
  input  logic [7:0]  o,
  input  logic        w,
  input  logic        r,
  output logic [7:0]  q,
  output logic        intr,
  output logic [2:0]  vect
);

  localparam logic [15:0] TickLast = 16'(TICK_DIV - 1);

  logic [7:0]  mask_q, pend_q, pend_d;
  logic        run_q;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  src_q, src_prev_q;
  logic        intr_q;
  logic [2:0]  vect_q, vect_d;

  logic        in_win;
  logic [15:0] off_full;
  logic [1:0]  off;
  logic        wr_mask, wr_pend, wr_tctl;
  logic [6:0]  events;
  logic        tick;
  logic [7:0]  masked;
  logic        unused_r;

  // Reads are side-effect free, so the read strobe carries no information here.
  assign unused_r = r;

  assign in_win   = (a >= BASE) && (a <= BASE + 16'd3);
  assign off_full = a - BASE;
  assign off      = off_full[1:0];
  assign wr_mask  = w && in_win && (off == 2'd0);
  assign wr_pend  = w && in_win && (off == 2'd1);
  assign wr_tctl  = w && in_win && (off == 2'd3);

  assign events = src_q & ~src_prev_q;
  assign tick   = run_q && (cnt_q == TickLast);
  assign masked = pend_q & mask_q;

  // Set beats W1C when both hit the same bit in one cycle.
  assign pend_d = (pend_q & ~(wr_pend ? o : 8'h00)) | {tick, events};

  always_comb begin
    if (!run_q || tick || (wr_tctl && !o[0])) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    vect_d = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (masked[i]) vect_d = 3'(i);
    end
  end

`ifdef IRQ_SYNC_EN
  logic [6:0] src_meta_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_meta_q <= 7'd0;
      src_q      <= 7'd0;
    end else begin
      src_meta_q <= src;
      src_q      <= src_meta_q;
    end
  end
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q <= 7'd0;
    end else begin
      src_q <= src;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_prev_q <= 7'd0;
      mask_q     <= 8'd0;
      pend_q     <= 8'd0;
      run_q      <= 1'b0;
      cnt_q      <= 16'd0;
      intr_q     <= 1'b0;
      vect_q     <= 3'd0;
    end else begin
      src_prev_q <= src_q;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      intr_q     <= |masked;
      vect_q     <= vect_d;
      if (wr_mask) mask_q <= o;
      if (wr_tctl) run_q <= o[0];
    end
  end

  always_comb begin
    q = 8'h00;
    if (in_win) begin
      case (off)
        2'd0:    q = mask_q;
        2'd1:    q = pend_q;
        2'd2:    q = {intr_q, 4'b0000, vect_q};
        default: q = {7'b0000000, run_q};
      endcase
    end
  end

  assign intr = intr_q;
  assign vect = vect_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Randomized bench for irq_ctl against a cycle-level behavioural model, plus directed corner cases.
module tb_irq_ctl;

  localparam logic [15:0] BASE = 16'h005C;
  localparam int TD = 10;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  src   = 7'd0;
  logic [15:0] a     = 16'd0;
  logic [7:0]  o     = 8'd0;
  logic        w     = 1'b0;
  logic        r     = 1'b0;
  logic [7:0]  q;
  logic        intr;
  logic [2:0]  vect;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [7:0] m_mask, m_pend;
  logic       m_run, m_intr;
  logic [2:0] m_vect;
  int         m_age;
  logic [6:0] hist [4];

  irq_ctl #(.BASE(BASE), .TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .src(src), .a(a), .o(o), .w(w), .r(r),
    .q(q), .intr(intr), .vect(vect)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_mask = 0; m_pend = 0; m_run = 0; m_intr = 0; m_vect = 0; m_age = 0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [15:0] addr);
    if (addr < BASE || addr > BASE + 16'd3) return 8'h00;
    case (int'(addr - BASE))
      0:       return m_mask;
      1:       return m_pend;
      2:       return {m_intr, 4'b0000, m_vect};
      default: return {7'b0, m_run};
    endcase
  endfunction

  // One clock edge of the specified behaviour, given the inputs present at that edge.
  task automatic m_edge(input logic [6:0] s, input logic wr, input logic [15:0] addr,
                        input logic [7:0] data);
    logic [7:0] en;
    logic [7:0] clr;
    logic [6:0] ev;
    logic       tk;
    bit         found;
    en = m_pend & m_mask;
    clr = 8'h00;
    m_intr = (en != 8'h00);
    m_vect = 3'd0;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      if (!found && en[i]) begin
        m_vect = 3'(i);
        found = 1;
      end
    end
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    ev = hist[LAT] & ~hist[LAT+1];
    tk = 1'b0;
    if (m_run) begin
      m_age++;
      tk = (m_age % TD == 0);
    end
    if (wr && addr >= BASE && addr <= BASE + 16'd3) begin
      case (int'(addr - BASE))
        0: m_mask = data;
        1: clr = data;
        3: begin
          if (data[0] != m_run) m_age = 0;
          m_run = data[0];
        end
        default: ;
      endcase
    end
    m_pend = (m_pend & ~clr) | {tk, ev};
  endtask

  task automatic step(input logic [6:0] s, input logic wr, input logic [15:0] addr,
                      input logic [7:0] data);
    src = s; w = wr; a = addr; o = data;
    @(posedge clock);
    m_edge(s, wr, addr, data);
    #1;
    w = 1'b0;
    check("intr", {7'b0, intr}, {7'b0, m_intr});
    check("vect", {5'b0, vect}, {5'b0, m_vect});
    check("q", q, m_read(addr));
  endtask

  task automatic idle(input int n, input logic [6:0] s, input logic [15:0] addr);
    for (int i = 0; i < n; i++) step(s, 1'b0, addr, 8'h00);
  endtask

  initial begin
    logic [6:0]  s_rand;
    logic [15:0] addr;
    m_reset();
    #23 reset = 1'b0;

    // Reset state: every register reads 0, and one past the window does too.
    for (int i = 0; i < 5; i++) begin
      a = BASE + 16'(i);
      #1 check("reset_q", q, 8'h00);
    end
    check("reset_intr", {7'b0, intr}, 8'h00);
    check("reset_vect", {5'b0, vect}, 8'h00);

    // Single pulse on src[2] with only that source enabled.
    step(7'h00, 1'b1, BASE, 8'h04);
    step(7'h04, 1'b0, BASE + 16'd1, 8'h00);
    idle(LAT, 7'h00, BASE + 16'd1);
    check("pulse_pend", q, 8'h04);
    idle(1, 7'h00, BASE + 16'd2);
    check("pulse_stat", q, 8'h82);
    step(7'h00, 1'b1, BASE + 16'd1, 8'h04);
    check("w1c_pend", q, 8'h00);
    idle(1, 7'h00, BASE + 16'd2);
    check("w1c_intr", {7'b0, intr}, 8'h00);

    // Two sources together: priority, then fall through to the next one.
    step(7'h00, 1'b1, BASE, 8'hFF);
    step(7'h22, 1'b0, BASE + 16'd2, 8'h00);
    idle(LAT + 1, 7'h00, BASE + 16'd2);
    check("prio_vect1", q, 8'h81);
    step(7'h00, 1'b1, BASE + 16'd1, 8'h02);
    idle(1, 7'h00, BASE + 16'd2);
    check("prio_vect5", q, 8'h85);
    step(7'h00, 1'b1, BASE + 16'd1, 8'h20);
    idle(1, 7'h00, BASE + 16'd2);
    check("prio_none", q, 8'h00);

    // Pending while masked, then unmask.
    step(7'h00, 1'b1, BASE, 8'h00);
    step(7'h08, 1'b0, BASE + 16'd1, 8'h00);
    idle(LAT + 1, 7'h00, BASE + 16'd1);
    check("masked_pend", q, 8'h08);
    check("masked_intr", {7'b0, intr}, 8'h00);
    step(7'h00, 1'b1, BASE, 8'h08);
    idle(1, 7'h00, BASE + 16'd2);
    check("unmask_stat", q, 8'h83);

    // Randomized traffic.
    s_rand = 7'h00;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 7; b++) if ($urandom_range(0, 7) == 0) s_rand[b] = ~s_rand[b];
      if ($urandom_range(0, 9) == 0) addr = 16'($urandom);
      else addr = BASE - 16'd2 + 16'($urandom_range(0, 7));
      step(s_rand, ($urandom_range(0, 4) == 0), addr, 8'($urandom));
    end

    // Tick: clean start, W1C coinciding with the wrap, then restart timing.
    step(7'h00, 1'b1, BASE + 16'd3, 8'h00);
    idle(3, 7'h00, BASE + 16'd1);
    step(7'h00, 1'b1, BASE + 16'd1, 8'hFF);
    step(7'h00, 1'b1, BASE + 16'd3, 8'h01);
    idle(TD - 1, 7'h00, BASE + 16'd1);
    check("tick_early", q, 8'h00);
    step(7'h00, 1'b1, BASE + 16'd1, 8'h80);
    check("tick_set_wins", q, 8'h80);
    idle(4, 7'h00, BASE + 16'd1);
    step(7'h00, 1'b1, BASE + 16'd3, 8'h00);
    step(7'h00, 1'b1, BASE + 16'd3, 8'h01);
    step(7'h00, 1'b1, BASE + 16'd1, 8'h80);
    idle(TD - 2, 7'h00, BASE + 16'd1);
    check("restart_early", q, 8'h00);
    idle(1, 7'h00, BASE + 16'd1);
    check("restart_tick", q, 8'h80);
    step(7'h00, 1'b1, BASE + 16'd3, 8'h00);

    // Level held high: exactly one event.
    step(7'h00, 1'b1, BASE + 16'd1, 8'hFF);
    idle(50, 7'h01, BASE + 16'd1);
    check("held_first", q, 8'h01);
    step(7'h01, 1'b1, BASE + 16'd1, 8'h01);
    idle(5, 7'h01, BASE + 16'd1);
    check("held_once", q, 8'h00);

    // Asynchronous reset mid-cycle with everything pending.
    step(7'h00, 1'b1, BASE + 16'd3, 8'h01);
    step(7'h00, 1'b1, BASE, 8'hFF);
    step(7'h7F, 1'b0, BASE + 16'd1, 8'h00);
    idle(TD + 2, 7'h00, BASE + 16'd1);
    check("pre_reset_pend", q, 8'hFF);
    #2 reset = 1'b1;
    m_reset();
    #1;
    check("areset_intr", {7'b0, intr}, 8'h00);
    check("areset_vect", {5'b0, vect}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      a = BASE + 16'(i);
      #0 check("areset_q", q, 8'h00);
    end
    #1 reset = 1'b0;
    idle(TD + 3, 7'h00, BASE + 16'd1);
    check("post_reset_idle", q, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
